// File: rtl/fetch_controller_pkg.sv
// Shared fetch-path definitions: controller state encoding and default widths/strides
// reused by the decode stage and the instruction memory model.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_DRAIN = 2'd1,
    FETCH_HALT  = 2'd2
  } fetch_state_t;

  localparam int FETCH_ADDR_W       = 64;
  localparam int FETCH_INST_W       = 32;
  localparam int FETCH_PC_STEP      = 4;
  localparam int FETCH_PC_STEP_PIPE = 16;

  // Unused memory is zero-filled, so an all-zero word marks the end of the program.
  function automatic logic is_halt_word(input logic [FETCH_INST_W-1:0] word);
    return word == '0;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO between fetch and decode; accepts a push on a full FIFO
// when a pop happens in the same cycle, and flushes all entries in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occupancy == '0);
  assign full    = (occupancy == CNT_W'(DEPTH));
  assign count   = occupancy;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so stale storage never leaks to decode.
  assign head_data = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, fetches one word per cycle from combinational
// instruction memory, buffers it for decode, and handles redirect/halt/restart.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int INST_W   = FETCH_INST_W,
  parameter int PC_STEP  = FETCH_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              restart,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t              state;
  fetch_state_t              state_next;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         pc_next;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [CNT_W-1:0]          fifo_count;
  logic [INST_W+ADDR_W-1:0]  fifo_head;
  logic                      fetch_slot;
  logic                      zero_word;
  logic                      empty_after;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .push_data ({mem_data, pc}),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign mem_addr   = pc;
  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_head[INST_W+ADDR_W-1:ADDR_W];
  assign inst_pc    = fifo_head[ADDR_W-1:0];
  assign halted     = (state == FETCH_HALT);
  assign fifo_pop   = inst_valid && inst_ready;

  // A fetch slot exists when running and the FIFO has room after this cycle's pop.
  assign fetch_slot  = (state == FETCH_RUN) && (!fifo_full || fifo_pop);
  assign zero_word   = is_halt_word(mem_data);
  assign empty_after = fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop);
  assign fifo_push   = fetch_slot && !zero_word && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect outranks restart, which in turn outranks ordinary fetch progress.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fifo_flush = 1'b0;
    if (redirect) begin
      fifo_flush = 1'b1;
      pc_next    = redirect_pc;
      state_next = FETCH_RUN;
    end else if (restart && state == FETCH_HALT) begin
      pc_next    = RESET_PC;
      state_next = FETCH_RUN;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (fetch_slot) begin
            if (zero_word) state_next = empty_after ? FETCH_HALT : FETCH_DRAIN;
            else           pc_next    = pc + ADDR_W'(PC_STEP);
          end
        end
        FETCH_DRAIN: begin
          if (empty_after) state_next = FETCH_HALT;
        end
        FETCH_HALT: begin
          state_next = FETCH_HALT;
        end
        default: begin
          state_next = FETCH_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a 4-byte-stride instance with a small program
// memory and a 16-byte-stride instance whose memory returns address|1.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [63:0] mem_addr_a;
  logic [31:0] mem_data_a;
  logic        inst_valid_a;
  logic        inst_ready_a = 1'b1;
  logic [31:0] inst_data_a;
  logic [63:0] inst_pc_a;
  logic        redirect_a = 1'b0;
  logic [63:0] redirect_pc_a = '0;
  logic        restart_a = 1'b0;
  logic        halted_a;

  logic [63:0] mem_addr_b;
  logic [31:0] mem_data_b;
  logic        inst_valid_b;
  logic [31:0] inst_data_b;
  logic [63:0] inst_pc_b;
  logic        redirect_b = 1'b0;
  logic [63:0] redirect_pc_b = '0;
  logic        halted_b;

  logic [31:0] prog [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_data_a = (mem_addr_a < 64'd256) ? prog[mem_addr_a[7:2]] : 32'h0;
  assign mem_data_b = mem_addr_b[31:0] | 32'h1;

  fetch_controller #(.PC_STEP(4)) dut_a (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready_a), .inst_data(inst_data_a),
    .inst_pc(inst_pc_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
    .restart(restart_a), .halted(halted_a)
  );

  fetch_controller #(.PC_STEP(16)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .inst_valid(inst_valid_b), .inst_ready(1'b1), .inst_data(inst_data_b),
    .inst_pc(inst_pc_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .restart(1'b0), .halted(halted_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (inst_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid_a); end
    checks++; if (halted_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted_a); end
    checks++; if (inst_data_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", inst_data_a); end
    checks++; if (inst_pc_a !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", inst_pc_a); end
    checks++; if (mem_addr_a !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr_a); end
    checks++; if (inst_valid_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_b: got %b expected 0", inst_valid_b); end
  endtask

  task automatic test_step16();
    logic [63:0] exp_pc [3];
    exp_pc[0] = 64'd0; exp_pc[1] = 64'd16; exp_pc[2] = 64'd32;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_valid_b !== 1'b1 || inst_pc_b !== exp_pc[i] || inst_data_b !== (exp_pc[i][31:0] | 32'h1)) begin
        errors++;
        $display("[TB] FAIL step16_seq%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h",
                 i, inst_valid_b, inst_pc_b, inst_data_b, exp_pc[i], exp_pc[i][31:0] | 32'h1);
      end
    end
    redirect_b = 1'b1;
    redirect_pc_b = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    redirect_b = 1'b0;
    checks++; if (inst_valid_b !== 1'b0 || mem_addr_b !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("[TB] FAIL step16_redirect: got v=%b addr=%h expected v=0 addr=fffffffffffffff0", inst_valid_b, mem_addr_b); end
    tick();
    checks++; if (inst_pc_b !== 64'hFFFF_FFFF_FFFF_FFF0 || inst_data_b !== 32'hFFFF_FFF1) begin errors++; $display("[TB] FAIL step16_top: got pc=%h d=%h expected pc=fffffffffffffff0 d=fffffff1", inst_pc_b, inst_data_b); end
    checks++; if (mem_addr_b !== 64'h0) begin errors++; $display("[TB] FAIL step16_wrap_addr: got %h expected 0", mem_addr_b); end
    tick();
    checks++; if (inst_pc_b !== 64'h0 || inst_data_b !== 32'h1) begin errors++; $display("[TB] FAIL step16_wrap_pc: got pc=%h d=%h expected pc=0 d=1", inst_pc_b, inst_data_b); end
  endtask

  task automatic test_basic_halt();
    prog[0] = 32'h8b1f03e5;
    prog[1] = 32'hf84000a4;
    prog[2] = 32'h0;
    inst_ready_a = 1'b1;
    do_reset();
    tick();
    checks++; if (inst_valid_a !== 1'b1 || inst_pc_a !== 64'h0 || inst_data_a !== 32'h8b1f03e5) begin errors++; $display("[TB] FAIL basic_first: got v=%b pc=%h d=%h expected v=1 pc=0 d=8b1f03e5", inst_valid_a, inst_pc_a, inst_data_a); end
    tick();
    checks++; if (inst_valid_a !== 1'b1 || inst_pc_a !== 64'h4 || inst_data_a !== 32'hf84000a4) begin errors++; $display("[TB] FAIL basic_second: got v=%b pc=%h d=%h expected v=1 pc=4 d=f84000a4", inst_valid_a, inst_pc_a, inst_data_a); end
    checks++; if (halted_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_not_halted: got %b expected 0", halted_a); end
    tick();
    checks++; if (halted_a !== 1'b1 || inst_valid_a !== 1'b0 || mem_addr_a !== 64'h8) begin errors++; $display("[TB] FAIL basic_halt: got h=%b v=%b addr=%h expected h=1 v=0 addr=8", halted_a, inst_valid_a, mem_addr_a); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_pc [3];
    logic [31:0] exp_d  [3];
    exp_pc[0] = 64'h0; exp_pc[1] = 64'h4; exp_pc[2] = 64'h8;
    exp_d[0] = 32'h8b1f03e5; exp_d[1] = 32'hf84000a4; exp_d[2] = 32'h00c0ffee;
    prog[2] = 32'h00c0ffee;
    prog[3] = 32'h0;
    inst_ready_a = 1'b0;
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    checks++; if (halted_a !== 1'b0 || mem_addr_a !== 64'h0) begin errors++; $display("[TB] FAIL restart: got h=%b addr=%h expected h=0 addr=0", halted_a, mem_addr_a); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (inst_valid_a !== 1'b1 || inst_pc_a !== 64'h0 || mem_addr_a !== 64'h8) begin errors++; $display("[TB] FAIL stall_hold: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=8", inst_valid_a, inst_pc_a, mem_addr_a); end
    inst_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_valid_a !== 1'b1 || inst_pc_a !== exp_pc[i] || inst_data_a !== exp_d[i]) begin
        errors++;
        $display("[TB] FAIL release_seq%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h",
                 i, inst_valid_a, inst_pc_a, inst_data_a, exp_pc[i], exp_d[i]);
      end
      tick();
    end
    checks++; if (halted_a !== 1'b1 || inst_valid_a !== 1'b0 || mem_addr_a !== 64'hc) begin errors++; $display("[TB] FAIL drain_halt: got h=%b v=%b addr=%h expected h=1 v=0 addr=c", halted_a, inst_valid_a, mem_addr_a); end
  endtask

  task automatic test_redirect();
    prog[16] = 32'h1111_0001;
    prog[17] = 32'h2222_0002;
    prog[18] = 32'h0;
    inst_ready_a = 1'b0;
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_a = 1'b1;
    redirect_pc_a = 64'h40;
    tick();
    redirect_a = 1'b0;
    checks++; if (inst_valid_a !== 1'b0 || mem_addr_a !== 64'h40) begin errors++; $display("[TB] FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=40", inst_valid_a, mem_addr_a); end
    tick();
    checks++; if (inst_valid_a !== 1'b1 || inst_pc_a !== 64'h40 || inst_data_a !== 32'h1111_0001) begin errors++; $display("[TB] FAIL redirect_target: got v=%b pc=%h d=%h expected v=1 pc=40 d=11110001", inst_valid_a, inst_pc_a, inst_data_a); end
    inst_ready_a = 1'b1;
    tick();
    checks++; if (inst_pc_a !== 64'h44 || inst_data_a !== 32'h2222_0002) begin errors++; $display("[TB] FAIL redirect_next: got pc=%h d=%h expected pc=44 d=22220002", inst_pc_a, inst_data_a); end
    tick();
    checks++; if (halted_a !== 1'b1) begin errors++; $display("[TB] FAIL redirect_halt: got %b expected 1", halted_a); end
  endtask

  task automatic test_redirect_restart();
    redirect_a = 1'b1;
    restart_a = 1'b1;
    redirect_pc_a = 64'h44;
    tick();
    redirect_a = 1'b0;
    restart_a = 1'b0;
    checks++; if (halted_a !== 1'b0 || mem_addr_a !== 64'h44 || inst_valid_a !== 1'b0) begin errors++; $display("[TB] FAIL redirect_wins: got h=%b addr=%h v=%b expected h=0 addr=44 v=0", halted_a, mem_addr_a, inst_valid_a); end
    tick();
    checks++; if (inst_pc_a !== 64'h44) begin errors++; $display("[TB] FAIL redirect_wins_pc: got %h expected 44", inst_pc_a); end
    redirect_a = 1'b1;
    redirect_pc_a = 64'h42;
    tick();
    redirect_a = 1'b0;
    tick();
    checks++; if (inst_pc_a !== 64'h42 || inst_data_a !== 32'h1111_0001 || mem_addr_a !== 64'h46) begin errors++; $display("[TB] FAIL unaligned: got pc=%h d=%h addr=%h expected pc=42 d=11110001 addr=46", inst_pc_a, inst_data_a, mem_addr_a); end
  endtask

  task automatic test_rst_midstream();
    rst = 1'b1;
    tick();
    checks++; if (inst_valid_a !== 1'b0 || mem_addr_a !== 64'h0 || halted_a !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset: got v=%b addr=%h h=%b expected v=0 addr=0 h=0", inst_valid_a, mem_addr_a, halted_a); end
    rst = 1'b0;
    tick();
    checks++; if (inst_valid_a !== 1'b1 || inst_pc_a !== 64'h0 || inst_data_a !== 32'h8b1f03e5) begin errors++; $display("[TB] FAIL post_reset_fetch: got v=%b pc=%h d=%h expected v=1 pc=0 d=8b1f03e5", inst_valid_a, inst_pc_a, inst_data_a); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    test_reset();
    test_step16();
    test_basic_halt();
    test_backpressure();
    test_redirect();
    test_redirect_restart();
    test_rst_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
